// File: rtl/mult_pkg.sv
// Shared types and sizing helpers for the iterative shift-add multiplier family.
package mult_pkg;

  typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

  function automatic int cnt_w(input int size);
    return $clog2(size + 1);
  endfunction

endpackage

// File: rtl/mult_step.sv
// One conditional add-and-shift iteration: acc + (mbit ? mcand << shamt : 0).
module mult_step #(
  parameter int SIZE  = 8,
  parameter int CNT_W = 4
) (
  input  logic [2*SIZE-1:0] acc_i,
  input  logic [SIZE-1:0]   mcand_i,
  input  logic              mbit_i,
  input  logic [CNT_W-1:0]  shamt_i,
  output logic [2*SIZE-1:0] acc_o
);

  logic [2*SIZE-1:0] mcand_ext;

  assign mcand_ext = {{SIZE{1'b0}}, mcand_i};
  assign acc_o     = mbit_i ? (acc_i + (mcand_ext << shamt_i)) : acc_i;

endmodule

// File: rtl/seq_multiplier.sv
// Iterative signed/unsigned multiplier, one multiplier bit per cycle, with
// valid/ready handshakes on both sides and output backpressure.
module seq_multiplier
  import mult_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              is_signed,
  input  logic [SIZE-1:0]   a,
  input  logic [SIZE-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*SIZE-1:0] c,
  output logic              over
);

  localparam int CNT_W = cnt_w(SIZE);
  localparam int PW    = 2 * SIZE;

  mult_state_t      state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [SIZE-1:0]  mcand_q, mcand_d;
  logic [SIZE-1:0]  mplier_q, mplier_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    c_q, c_d;
  logic             neg_q, neg_d;
  logic             sgn_q, sgn_d;
  logic             over_q, over_d;
  logic             mbit;
  logic [PW-1:0]    step_acc;
  logic [PW-1:0]    prod;

  // Magnitude of -2^(SIZE-1) wraps to 2^(SIZE-1), which fits as unsigned.
  function automatic logic [SIZE-1:0] magnitude(input logic [SIZE-1:0] v, input logic s);
    return (s && v[SIZE-1]) ? -v : v;
  endfunction

  function automatic logic over_flag(input logic [PW-1:0] p, input logic s);
    logic [SIZE:0] hi;
    hi = p[PW-1:SIZE-1];
    if (s) return !((hi == '0) || (hi == '1));
    return p[PW-1:SIZE] != '0;
  endfunction

  assign mbit = |(mplier_q & ({{(SIZE-1){1'b0}}, 1'b1} << count_q));

  mult_step #(.SIZE(SIZE), .CNT_W(CNT_W)) u_step (
    .acc_i   (acc_q),
    .mcand_i (mcand_q),
    .mbit_i  (mbit),
    .shamt_i (count_q),
    .acc_o   (step_acc)
  );

  // Negate only a nonzero magnitude so a zero product never appears as -0.
  assign prod = (neg_q && (step_acc != '0)) ? -step_acc : step_acc;

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    c_d      = c_q;
    neg_d    = neg_q;
    sgn_d    = sgn_q;
    over_d   = over_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d  = CALC;
          count_d  = '0;
          acc_d    = '0;
          mcand_d  = magnitude(a, is_signed);
          mplier_d = magnitude(b, is_signed);
          neg_d    = is_signed & (a[SIZE-1] ^ b[SIZE-1]);
          sgn_d    = is_signed;
        end
      end
      CALC: begin
        acc_d   = step_acc;
        count_d = count_q + CNT_W'(1);
        if (count_q == CNT_W'(SIZE - 1)) begin
          state_d = DONE;
          c_d     = prod;
          over_d  = over_flag(prod, sgn_q);
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      c_q     <= '0;
      over_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      c_q     <= c_d;
      over_q  <= over_d;
    end
  end

  // Working operands and accumulator are always reloaded on accept.
  always_ff @(posedge clk) begin
    mcand_q  <= mcand_d;
    mplier_q <= mplier_d;
    acc_q    <= acc_d;
    neg_q    <= neg_d;
    sgn_q    <= sgn_d;
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign c         = c_q;
  assign over      = over_q;

endmodule

// File: tb/tb_seq_multiplier.sv
// Directed and model-checked stimulus for seq_multiplier at SIZE 2, 8 and 16.
module tb_seq_multiplier;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        iv[3];
  logic        sg[3];
  logic        ordy[3];
  logic [15:0] a_in[3];
  logic [15:0] b_in[3];
  logic        ir[3];
  logic        ov[3];
  logic        ovf[3];
  logic [3:0]  c2;
  logic [15:0] c8;
  logic [31:0] c16;

  int checks = 0;
  int errors = 0;

  seq_multiplier #(.SIZE(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[0]), .in_ready(ir[0]), .is_signed(sg[0]),
    .a(a_in[0][1:0]), .b(b_in[0][1:0]), .out_valid(ov[0]), .out_ready(ordy[0]),
    .c(c2), .over(ovf[0])
  );

  seq_multiplier #(.SIZE(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[1]), .in_ready(ir[1]), .is_signed(sg[1]),
    .a(a_in[1][7:0]), .b(b_in[1][7:0]), .out_valid(ov[1]), .out_ready(ordy[1]),
    .c(c8), .over(ovf[1])
  );

  seq_multiplier #(.SIZE(16)) u_dut16 (
    .clk(clk), .rst_n(rst_n), .in_valid(iv[2]), .in_ready(ir[2]), .is_signed(sg[2]),
    .a(a_in[2]), .b(b_in[2]), .out_valid(ov[2]), .out_ready(ordy[2]),
    .c(c16), .over(ovf[2])
  );

  function automatic int sz_of(input int d);
    return (d == 0) ? 2 : (d == 1) ? 8 : 16;
  endfunction

  function automatic logic [31:0] c_of(input int d);
    case (d)
      0:       return {28'd0, c2};
      1:       return {16'd0, c8};
      default: return c16;
    endcase
  endfunction

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Independent reference: integer multiply of the interpreted operands.
  task automatic ref_mult(input int size, input bit s, input logic [15:0] av, input logic [15:0] bv,
                          output logic [31:0] ec, output logic eo);
    longint x, y, p, half, mask;
    x = longint'(av) & ((longint'(1) << size) - 1);
    y = longint'(bv) & ((longint'(1) << size) - 1);
    if (s && av[size-1]) x = x - (longint'(1) << size);
    if (s && bv[size-1]) y = y - (longint'(1) << size);
    p    = x * y;
    mask = (longint'(1) << (2 * size)) - 1;
    ec   = 32'(p & mask);
    half = longint'(1) << (size - 1);
    if (s) eo = (p < -half) || (p > half - 1);
    else   eo = (p >= (longint'(1) << size));
  endtask

  // Issue one op, verify latency, result and hold behaviour under `stall` cycles of backpressure.
  task automatic do_op(input string tag, input int d, input bit s, input logic [15:0] av,
                       input logic [15:0] bv, input int stall, input logic [31:0] ec, input logic eo);
    int lat;
    logic [31:0] held_c;
    logic held_o;
    check_val({tag, ".in_ready"}, 32'(ir[d]), 32'd1);
    a_in[d] = av; b_in[d] = bv; sg[d] = s; iv[d] = 1'b1; ordy[d] = (stall == 0);
    tick();
    iv[d] = 1'b0;
    a_in[d] = 16'(~av); b_in[d] = 16'(~bv); sg[d] = ~s;
    lat = 0;
    while (!ov[d] && lat < 64) begin
      tick();
      lat++;
    end
    check_val({tag, ".latency"}, 32'(lat), 32'(sz_of(d)));
    check_val({tag, ".c"}, c_of(d), ec);
    check_val({tag, ".over"}, 32'(ovf[d]), 32'(eo));
    held_c = c_of(d);
    held_o = ovf[d];
    for (int i = 0; i < stall; i++) begin
      iv[d] = 1'b1;
      tick();
      check_val({tag, ".hold_c"}, c_of(d), held_c);
      check_val({tag, ".hold_over"}, 32'(ovf[d]), 32'(held_o));
      check_val({tag, ".hold_busy"}, {30'd0, ov[d], ir[d]}, 32'b10);
    end
    iv[d] = 1'b1;
    ordy[d] = 1'b1;
    tick();
    iv[d] = 1'b0;
    ordy[d] = 1'b0;
    check_val({tag, ".release"}, {30'd0, ov[d], ir[d]}, 32'b01);
  endtask

  initial begin
    logic [31:0] ec;
    logic eo;
    logic [15:0] ra, rb;
    bit rs;
    for (int d = 0; d < 3; d++) begin
      iv[d] = 1'b0; sg[d] = 1'b0; ordy[d] = 1'b0; a_in[d] = '0; b_in[d] = '0;
    end
    rst_n = 1'b0;
    tick(); tick();
    for (int d = 0; d < 3; d++) begin
      check_val("reset.c", c_of(d), 32'd0);
      check_val("reset.over", 32'(ovf[d]), 32'd0);
      check_val("reset.out_valid", 32'(ov[d]), 32'd0);
    end
    rst_n = 1'b1;
    tick();
    for (int d = 0; d < 3; d++) check_val("reset.in_ready", 32'(ir[d]), 32'd1);

    do_op("u2_3x3", 0, 1'b0, 16'h3, 16'h3, 0, 32'h9, 1'b1);
    do_op("u2_3x1", 0, 1'b0, 16'h3, 16'h1, 1, 32'h3, 1'b0);
    do_op("u2_3x0", 0, 1'b0, 16'h3, 16'h0, 0, 32'h0, 1'b0);
    do_op("s2_m1xm2", 0, 1'b1, 16'h3, 16'h2, 0, 32'h2, 1'b1);
    do_op("s8_min_sq", 1, 1'b1, 16'h80, 16'h80, 0, 32'h4000, 1'b1);
    do_op("s8_m1x5", 1, 1'b1, 16'hFF, 16'h05, 0, 32'hFFFB, 1'b0);
    do_op("s8_0xneg", 1, 1'b1, 16'h00, 16'h9C, 0, 32'h0000, 1'b0);
    do_op("u8_stall", 1, 1'b0, 16'h12, 16'h34, 5, 32'h03A8, 1'b1);
    do_op("s16_max_sq", 2, 1'b1, 16'h7FFF, 16'h7FFF, 2, 32'h3FFF0001, 1'b1);

    // Reset in the third CALC cycle aborts the op.
    a_in[1] = 16'h55; b_in[1] = 16'h66; sg[1] = 1'b0; iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    tick(); tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("rst_mid.out_valid", 32'(ov[1]), 32'd0);
    check_val("rst_mid.c", c_of(1), 32'd0);
    check_val("rst_mid.in_ready", 32'(ir[1]), 32'd1);
    do_op("u8_after_rst", 1, 1'b0, 16'h0F, 16'h11, 0, 32'h00FF, 1'b0);

    for (int n = 0; n < 30; n++) begin
      for (int d = 0; d < 3; d++) begin
        ra = 16'($urandom);
        rb = 16'($urandom);
        rs = 1'($urandom);
        ref_mult(sz_of(d), rs, ra, rb, ec, eo);
        do_op("rand", d, rs, ra, rb, int'($urandom_range(0, 3)), ec, eo);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
